// File: rtl/fpu_share_arb.sv
// fpu_share_arb
// Shares one fixed-latency FPU arithmetic unit among NREQ requesters.
// A round-robin grant picks at most one eligible requester per cycle. Its
// operands are registered into the unit, and a {valid, id} tag travels
// alongside the op through a LAT+1 stage pipeline. When the tag leaves the
// last stage, the unit result is captured into that requester's response
// register. The response is held there until the requester accepts it.
//
// Ports
//   clk, rstn           clock (rising edge), async active-low reset
//   req_valid/ready     per-requester issue handshake (ready is one-hot grant)
//   req_x1/x2           packed operands, requester i at [i*W +: W]
//   rsp_valid/ready     per-requester response handshake
//   rsp_y/rsp_ovf       held result and overflow per requester
//   u_valid/u_x1/u_x2   registered issue to the unit
//   u_y/u_ovf           unit result, valid LAT cycles after issue
module fpu_share_arb #(
  parameter int NREQ = 2,
  parameter int LAT  = 0,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x1,
  input  logic [NREQ*W-1:0] req_x2,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [NREQ*W-1:0] rsp_y,
  output logic [NREQ-1:0]   rsp_ovf,
  output logic              u_valid,
  output logic [W-1:0]      u_x1,
  output logic [W-1:0]      u_x2,
  input  logic [W-1:0]      u_y,
  input  logic              u_ovf
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  logic [NREQ-1:0] inflight;
  logic [NREQ-1:0] busy;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] upper_mask;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            accept;
  logic [IDW-1:0]  rr_ptr;
  logic [W-1:0]    sel_x1;
  logic [W-1:0]    sel_x2;

  logic            tag_v  [0:LAT];
  logic [IDW-1:0]  tag_id [0:LAT];
  logic            cap_v;
  logic [IDW-1:0]  cap_id;

  // A held response still counts as busy, so a requester cannot be
  // re-granted in the same cycle in which it hands its response back.
  assign busy     = inflight | rsp_valid;
  assign eligible = req_valid & ~busy;

  // Round-robin search: look first at indices at or above the pointer.
  // If none of those is eligible, wrap around to the lowest eligible index.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      upper_mask[i] = (IDW'(i) >= rr_ptr);
    end
    masked   = eligible & upper_mask;
    pick     = (|masked) ? masked : eligible;
    grant    = '0;
    grant_id = '0;
    accept   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!accept && pick[i]) begin
        accept   = 1'b1;
        grant[i] = 1'b1;
        grant_id = IDW'(i);
      end
    end
  end

  always_comb begin
    sel_x1 = '0;
    sel_x2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_x1 = req_x1[i*W +: W];
        sel_x2 = req_x2[i*W +: W];
      end
    end
  end

  assign req_ready = grant;

  // The last tag stage marks the cycle in which u_y/u_ovf belong to that op.
  assign cap_v  = tag_v[LAT];
  assign cap_id = tag_id[LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      u_valid <= 1'b0;
      u_x1    <= '0;
      u_x2    <= '0;
      rr_ptr  <= '0;
      for (int s = 0; s <= LAT; s++) begin
        tag_v[s]  <= 1'b0;
        tag_id[s] <= '0;
      end
    end else begin
      u_valid   <= accept;
      tag_v[0]  <= accept;
      tag_id[0] <= grant_id;
      for (int s = 1; s <= LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
      if (accept) begin
        u_x1   <= sel_x1;
        u_x2   <= sel_x2;
        rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      end
    end
  end

  // For a given requester, capture cannot coincide with a grant or with a
  // handshake, because busy blocks a second issue. The else-branch therefore
  // only handles the independent set/clear events.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight  <= '0;
      rsp_valid <= '0;
      rsp_y     <= '0;
      rsp_ovf   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (cap_v && (cap_id == IDW'(i))) begin
          rsp_valid[i]       <= 1'b1;
          rsp_y[i*W +: W]    <= u_y;
          rsp_ovf[i]         <= u_ovf;
          inflight[i]        <= 1'b0;
        end else begin
          if (rsp_valid[i] && rsp_ready[i]) begin
            rsp_valid[i] <= 1'b0;
          end
          if (grant[i]) begin
            inflight[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule
